// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher stream-out path.
package cipher_pkg;

    localparam logic TYPE_OUT_ENC = 1'b0;
    localparam logic TYPE_OUT_DEC = 1'b1;

    localparam int BLOCK_W       = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 4;

    // One stored result block: {type, data}, 129 bits.
    typedef struct packed {
        logic               typ;
        logic [BLOCK_W-1:0] data;
    } blk_entry_t;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/cipher_blk_fifo.sv
// Generic synchronous FIFO with async reset, exposing the head entry and fill level.
// Latency: written entry visible at head the cycle after push. No internal guards; caller gates push/pop.
module cipher_blk_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 129,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  diff;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // At full with a concurrent pop, this write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign diff  = wr_ptr - rd_ptr;
    assign level = LW'(diff);

endmodule

// File: rtl/cipher_out_unpacker.sv
// Buffers 128-bit cipher result blocks and serializes each into four 32-bit words, MS word first.
// Latency: 1 cycle from vin to m_valid when empty. No upstream backpressure: almost_full throttles, drops set sticky overflow.
// Optional CIPHER_UNPACK_BYTESWAP_EN byte-reverses every output word.
module cipher_out_unpacker
    import cipher_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vin,
    input  logic               tin,
    input  logic [BLOCK_W-1:0] din,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_type,
    output logic               m_last,
    output logic [LW-1:0]      level,
    output logic               almost_full,
    output logic               overflow,
    input  logic               ovf_clr
);

    blk_entry_t        wr_entry;
    blk_entry_t        head;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              xfer;
    logic [1:0]        idx;
    logic [WORD_W-1:0] word;

    assign wr_entry = '{typ: tin, data: din};

    assign m_valid = !empty;
    assign xfer    = m_valid && m_ready;
    assign pop     = xfer && (idx == 2'd3);
    assign push    = vin && (!full || pop);
    assign drop    = vin && full && !pop;

    cipher_blk_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(blk_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .head  (head),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (xfer) idx <= idx + 2'd1;
            // A drop in the same cycle as a clear keeps overflow set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        word = '0;
        case (idx)
            2'd0: word = head.data[127:96];
            2'd1: word = head.data[95:64];
            2'd2: word = head.data[63:32];
            2'd3: word = head.data[31:0];
            default: word = '0;
        endcase
    end

`ifdef CIPHER_UNPACK_BYTESWAP_EN
    assign m_data = empty ? '0 : bswap32(word);
`else
    assign m_data = empty ? '0 : word;
`endif
    assign m_type      = empty ? TYPE_OUT_ENC : head.typ;
    assign m_last      = !empty && (idx == 2'd3);
    assign almost_full = (DEPTH - int'(level)) <= AFULL_LVL;

endmodule

// File: tb/tb_cipher_out_unpacker.sv
// Directed bench for cipher_out_unpacker: vector table plus hand sequences for overflow, full push/pop and reset.
module tb_cipher_out_unpacker;
    import cipher_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          vin;
    logic          tin;
    logic [127:0]  din;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_type;
    logic          m_last;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          overflow;
    logic          ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    cipher_out_unpacker #(.DEPTH(DEPTH), .AFULL_LVL(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .vin         (vin),
        .tin         (tin),
        .din         (din),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_type      (m_type),
        .m_last      (m_last),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         vin;
        logic         tin;
        logic         rdy;
        logic         e_valid;
        logic [31:0]  e_word;
        logic         e_type;
        logic         e_last;
        logic [2:0]   e_level;
    } vec_t;

    localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    vec_t tbl [14];

    function automatic vec_t mk(input logic v, input logic t, input logic r, input logic ev,
                                input logic [31:0] ew, input logic et, input logic el,
                                input logic [2:0] elv);
        vec_t x;
        x.vin = v; x.tin = t; x.rdy = r; x.e_valid = ev; x.e_word = ew;
        x.e_type = et; x.e_last = el; x.e_level = elv;
        return x;
    endfunction

    function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef CIPHER_UNPACK_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] blk(input int b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++)
            r[127 - 32*w -: 32] = 32'hB000_0000 | 32'(b * 16 + w);
        return r;
    endfunction

    function automatic logic [31:0] wrd(input logic [127:0] b, input int i);
        return 32'(b >> (32 * (3 - i)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [127:0] b, input int i, input logic t);
        chk({tag, " valid"}, 32'(m_valid), 32'd1);
        chk({tag, " data"},  m_data, xw(wrd(b, i)));
        chk({tag, " type"},  32'(m_type), 32'(t));
        chk({tag, " last"},  32'(m_last), 32'(i == 3));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; tin = 1'b0; din = '0; m_ready = 1'b0; ovf_clr = 1'b0;

        // Word expectations are unswapped here; xw() applies the build's byte order.
        tbl[0]  = mk(1, TYPE_OUT_ENC, 1, 1, 32'h00112233, 0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 1, 32'h44556677, 0, 0, 1);
        tbl[2]  = mk(0, 0, 1, 1, 32'h8899AABB, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 1, 32'hCCDDEEFF, 0, 1, 1);
        tbl[4]  = mk(0, 0, 1, 0, 32'h00000000, 0, 0, 0);
        tbl[5]  = mk(1, TYPE_OUT_DEC, 0, 1, 32'h00112233, 1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1, 32'h00112233, 1, 0, 1);
        tbl[7]  = mk(0, 0, 1, 1, 32'h44556677, 1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, 32'h44556677, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, 32'h44556677, 1, 0, 1);
        tbl[10] = mk(0, 0, 1, 1, 32'h8899AABB, 1, 0, 1);
        tbl[11] = mk(0, 0, 1, 1, 32'hCCDDEEFF, 1, 1, 1);
        tbl[12] = mk(0, 0, 0, 1, 32'hCCDDEEFF, 1, 1, 1);
        tbl[13] = mk(0, 0, 1, 0, 32'h00000000, 0, 0, 0);

        #1;
        chk("rst valid", 32'(m_valid), 0);
        chk("rst last",  32'(m_last), 0);
        chk("rst data",  m_data, 0);
        chk("rst type",  32'(m_type), 0);
        chk("rst level", 32'(level), 0);
        chk("rst afull", 32'(almost_full), 0);
        chk("rst ovf",   32'(overflow), 0);
        #12;
        rst = 1'b0;
        step();

        // Single block and backpressure vectors
        for (int i = 0; i < 14; i++) begin
            vin = tbl[i].vin; tin = tbl[i].tin; din = BLK; m_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d valid", i), 32'(m_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d data", i),  m_data, xw(tbl[i].e_word));
            chk($sformatf("vec%0d type", i),  32'(m_type), 32'(tbl[i].e_type));
            chk($sformatf("vec%0d last", i),  32'(m_last), 32'(tbl[i].e_last));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].e_level));
        end
        vin = 1'b0;

        // m_ready while empty must not move the word index
        m_ready = 1'b1;
        step(); step();
        chk("idle valid", 32'(m_valid), 0);

        // Overflow: six back-to-back blocks into a stalled 4-deep FIFO
        m_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            vin = 1'b1; tin = 1'(b); din = blk(b);
            step();
            if (b == 1) chk("ovf afull after B", 32'(almost_full), 0);
            if (b == 2) chk("ovf afull after C", 32'(almost_full), 1);
            if (b == 2) chk("ovf level after C", 32'(level), 3);
            if (b == 3) chk("ovf flag after D", 32'(overflow), 0);
            if (b == 4) chk("ovf flag after E", 32'(overflow), 1);
        end
        vin = 1'b0;
        chk("ovf level", 32'(level), 4);
        chk("ovf afull", 32'(almost_full), 1);
        chk("ovf flag",  32'(overflow), 1);
        chk_word("ovf first word", blk(0), 0, 0);
        m_ready = 1'b1;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 4; w++) begin
                chk_word($sformatf("drain b%0d w%0d", b, w), blk(b), w, 1'(b));
                step();
            end
        chk("drain valid", 32'(m_valid), 0);
        chk("drain level", 32'(level), 0);
        chk("drain ovf held", 32'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf cleared", 32'(overflow), 0);

        // Push at full coinciding with the head's final pop
        m_ready = 1'b0;
        for (int b = 10; b < 14; b++) begin
            vin = 1'b1; tin = 1'(b); din = blk(b);
            step();
        end
        vin = 1'b0;
        chk("full level", 32'(level), 4);
        m_ready = 1'b1;
        step(); step(); step();
        chk_word("full idx3", blk(10), 3, 0);
        vin = 1'b1; tin = 1'b0; din = blk(14);
        step();
        vin = 1'b0;
        chk("fullpp level", 32'(level), 4);
        chk("fullpp ovf",   32'(overflow), 0);
        chk_word("fullpp next", blk(11), 0, 1);

        // Drop together with clear: set wins, head untouched
        m_ready = 1'b0; vin = 1'b1; din = blk(99); ovf_clr = 1'b1;
        step();
        vin = 1'b0; ovf_clr = 1'b0;
        chk("setwins ovf", 32'(overflow), 1);
        chk_word("setwins head", blk(11), 0, 1);
        m_ready = 1'b1;
        for (int b = 11; b < 15; b++)
            for (int w = 0; w < 4; w++) begin
                chk_word($sformatf("fulldrain b%0d w%0d", b, w), blk(b), w, (b == 14) ? 1'b0 : 1'(b));
                step();
            end
        chk("fulldrain valid", 32'(m_valid), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Asynchronous reset mid-block
        vin = 1'b1; tin = 1'b1; din = blk(20);
        step();
        vin = 1'b0;
        step(); step();
        chk_word("mid idx2", blk(20), 2, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst valid", 32'(m_valid), 0);
        chk("arst level", 32'(level), 0);
        chk("arst last",  32'(m_last), 0);
        chk("arst data",  m_data, 0);
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b1; tin = 1'b0; din = blk(21);
        step();
        vin = 1'b0;
        for (int w = 0; w < 4; w++) begin
            chk_word($sformatf("post-rst w%0d", w), blk(21), w, 0);
            step();
        end
        chk("post-rst valid", 32'(m_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_out_unpacker.md
Name: cipher_out_unpacker

Overview:
- Consumer for the cipher core's stream-out interface (vout/tout/dout, 128-bit, no backpressure).
- Buffers whole result blocks in a small FIFO and serializes each one into four 32-bit words on a valid/ready master stream toward the host/bus side.
- Because the core cannot be stalled, the block provides almost-full throttling and sticky overflow reporting.

Parameters:
- DEPTH, 4, FIFO capacity in 128-bit blocks; power of two, >= 2.
- AFULL_LVL, 1, almost_full asserts when free entries <= AFULL_LVL; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- vin  in  1  block valid (driven by core vout).
- tin  in  1  block type: 0 = ENC result, 1 = DEC result (core tout).
- din  in  128  block data (core dout).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  32  output word.
- m_type  out  1  type of the block the current word belongs to.
- m_last  out  1  high on the 4th (final) word of a block.
- level  out  $clog2(DEPTH+1)  blocks currently stored.
- almost_full  out  1  (DEPTH - level) <= AFULL_LVL.
- overflow  out  1  sticky: a valid block was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync deassert by system): FIFO empty, level=0, word index=0, overflow=0. Outputs m_valid=0, m_last=0, almost_full=0 (AFULL_LVL<DEPTH). m_data=0 and m_type=0 while empty.
- Storage: each entry is {tin, din}, 129 bits. Write and read pointers are log2(DEPTH) bits wide plus a wrap bit. Pointers wrap modulo DEPTH.
- Push on vin=1 when not full, or when full and the head's final word handshakes in the same cycle (simultaneous push/pop at full is accepted; level unchanged).
- vin=1 while full with no concurrent final pop: block dropped, overflow set next edge. overflow holds until ovf_clr=1. If a drop and ovf_clr occur in the same cycle, set wins.
- vin=0: din/tin ignored.
- Read: m_valid = !empty, derived only from registers, never combinationally from vin.
- Latency: vin sampled at edge N gives m_valid=1 in the cycle after edge N (1 cycle) when the FIFO was empty.
- Serialization: a 2-bit word index selects from the head entry, most-significant first:
  - idx0 = din[127:96]
  - idx1 = din[95:64]
  - idx2 = din[63:32]
  - idx3 = din[31:0]
- m_type = head tin for all four words. m_last = (idx==3).
- Handshake: a word transfers when m_valid & m_ready; idx increments.
  - On transfer at idx==3: idx returns to 0, the head is popped, and the next block's word 0 appears the following cycle with no bubble if the FIFO is non-empty.
- While m_valid & !m_ready: m_data, m_type, m_last held stable, and m_valid stays high. A push never alters the head entry.
- m_ready while empty: ignored; idx unchanged.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Saturates logically at DEPTH, since no push occurs when full without a pop.
- Reset mid-block: partial block discarded; after release the next block starts at idx0.
- Throughput: 1 block per 4 cycles at the output. The core may burst 1 block/cycle, so the upstream issuer must stop on almost_full, allowing for core pipeline depth when choosing AFULL_LVL.

Optional Feature:
- Macro: CIPHER_UNPACK_BYTESWAP_EN.
- Defined: each output word is byte-reversed, e.g. idx0 → m_data = {din[103:96], din[111:104], din[119:112], din[127:120]}, for little-endian hosts.
- Undefined: words are output unmodified, as above. Word order, handshake and flags are identical in both builds.

Decomposition:
- Shared package cipher_pkg holds:
  - TYPE_OUT_ENC=1'b0, TYPE_OUT_DEC=1'b1
  - BLOCK_W=128, WORD_W=32, WORDS_PER_BLK=4
  - typedef for the 129-bit {type, data} entry
- One sub-module: cipher_blk_fifo (generic synchronous FIFO, async reset, exposing head entry, empty/full/level, push/pop).
- Serializer, flags and byteswap stay in cipher_out_unpacker.

Test Plan:
- Single block: vin=1, tin=0, din=128'h00112233_445566778_899AABB_CCDDEEFF corrected to 128'h00112233_44556677_8899AABB_CCDDEEFF, m_ready=1 → m_valid from next cycle. Words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles; m_last only on the 4th; m_type=0; then m_valid=0.
- Backpressure: same block, tin=1, m_ready pattern 0,1,0,0,1,1,0,1 → each word held stable while stalled; exactly 4 transfers in order; m_type=1 throughout.
- Overflow: DEPTH=4, m_ready=0, 6 back-to-back vin blocks A..F → level=4, almost_full=1 (AFULL_LVL=1, set after 3rd). overflow=1 after E; draining yields A, B, C, D only. ovf_clr pulse → overflow=0.
- Push at full with final pop: FIFO full, head at idx3, m_ready=1 and vin=1 same cycle → block accepted, level stays 4, overflow stays 0, no bubble between blocks.
- Async reset mid-block: assert rst after idx1 transfer (between edges) → m_valid=0, level=0 immediately. After release, a new block outputs from its word 0.
- Byteswap build (CIPHER_UNPACK_BYTESWAP_EN): first block above → words 33221100, 77665544, BBAA9988, FFEEDDCC.
